accl_conv_sequencer: RTL and testbench
======================================

ACCL_CONV_SEQUENCER -- requirements
Module: accl_conv_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/coefficient word width.
REQ-002 SHALL have parameter ADDR_W, default 10, bus word-address width; top 2 bits are the routing field.
REQ-003 SHALL have parameter NUM_COEFFS, default 9, filter taps per window (1..2^(ADDR_W-2)).
REQ-004 SHALL have parameter MAC_LATENCY, default 5, cycles from last operand to valid MAC result (>=1).
REQ-005 SHALL have parameter RESULT_DEPTH, default 24, result FIFO entries (>=2).
REQ-006 SHALL use one clock; reset is synchronous and active-high: ports clk (in, 1, rising-edge clock) and reset (in, 1, synchronous active-high reset).
REQ-007 SHALL have ports avs_address in ADDR_W, avs_write in 1, avs_writedata in DATA_W, avs_read in 1 (bus slave).
REQ-008 SHALL have ports avs_readdata out DATA_W, avs_readdatavalid out 1 (read response).
REQ-009 SHALL have ports mac_valid out 1, mac_first out 1, mac_last out 1, mac_a out DATA_W (coefficient), mac_b out DATA_W (data).
REQ-010 SHALL have port mac_result in DATA_W, sampled per REQ-018.
REQ-011 SHALL have port busy out 1, high whenever state is not s_Idle.

Function
REQ-012 SHALL route bus accesses by avs_address[ADDR_W-1:ADDR_W-2]: 0 control, 1 coeff, 2 data, 3 result.
REQ-013 SHALL store coeff/data writes at index avs_address[ADDR_W-3:0]; index >= NUM_COEFFS ignored; writes ignored while busy.
REQ-014 Control write: bit0=start, bit1=clear; control read returns {overflow at bit2, busy at bit0, result count at bits[15:8]}, other bits 0.
REQ-015 State machine s_Idle, s_ReadInput, s_WaitForCalc, s_ReadResult; start in s_Idle -> s_ReadInput next cycle; start while busy ignored.
REQ-016 s_ReadInput: NUM_COEFFS consecutive cycles, mac_valid=1, mac_a=coeff[i], mac_b=data[i], i=0..NUM_COEFFS-1; mac_first at i=0, mac_last at i=NUM_COEFFS-1 (both at NUM_COEFFS=1); then s_WaitForCalc.
REQ-017 s_WaitForCalc: exactly MAC_LATENCY cycles, mac_valid=0, then s_ReadResult.
REQ-018 s_ReadResult: one cycle, push mac_result into result FIFO, then s_Idle; start written at cycle T gives busy T+1..T+NUM_COEFFS+MAC_LATENCY+1.
REQ-019 FIFO full at push: result dropped, sticky overflow set; overflow cleared only by clear or reset.
REQ-020 Any read in result region pops FIFO head; empty read returns 0, no pop.
REQ-021 Pop and push same cycle: both occur, count unchanged, no overflow even if full.
REQ-022 Clear: empties FIFO, clears overflow; a push coincident with clear is discarded; sequence in flight continues.
REQ-023 avs_readdatavalid pulses, and avs_readdata updates, exactly 1 cycle after avs_read; avs_read and avs_write together: write ignored.
REQ-024 Read/write pointers wrap modulo RESULT_DEPTH (non-power-of-two supported).

Reset
REQ-025 Reset SHALL force s_Idle, FIFO empty, overflow 0, and all outputs 0; coefficient/data contents undefined.
REQ-026 Reset mid-sequence SHALL abort it with no push; first post-reset start behaves per REQ-018.

Structure
REQ-027 MacStateType, routing codes, AddrRoutingBits, MacEngineLatency, ResultBufferSize and FloatValue_1_0 SHALL live in AcceleratorPackage; parameter defaults taken from it.
REQ-028 Result FIFO SHALL be a sub-module accl_result_fifo (parameters DATA_W, DEPTH; push, pop, clear, full, empty, count).

Verification
REQ-029 Coeff[0..8]=0x3f800000, data[i]=i, start at T -> mac_valid T+1..T+9, mac_first T+1, mac_last T+9, mac_b sequence 0..8, busy low at T+16.
REQ-030 Mock MAC drives 0x41100000 during s_ReadResult -> control count=1; result read returns 0x41100000 at next cycle with readdatavalid; count 0.
REQ-031 25 sequences, no reads -> count 24, overflow=1; 24 reads return first 24 results in order; 25th read returns 0.
REQ-032 Full FIFO, result read coincident with push -> count stays 24, overflow stays 0.
REQ-033 Start again at T+5 and coeff write at T+3 -> both ignored; reset at T+6 -> busy 0 at T+7, count 0, no push.
REQ-034 Write coeff index 9 (NUM_COEFFS=9) -> no effect; clear while busy -> count 0, sequence completes and pushes one entry.

Source files
------------

// File: rtl/accl_conv_sequencer_pkg.sv
// Shared types and constants for the convolution sequencer: FSM states,
// bus routing codes, control/status bit positions and default sizes.
package AcceleratorPackage;

    typedef enum logic [1:0] {
        s_Idle,
        s_ReadInput,
        s_WaitForCalc,
        s_ReadResult
    } MacStateType;

    // Width of the routing field at the top of the bus word address
    localparam int AddrRoutingBits = 2;

    localparam logic [1:0] ROUTE_CONTROL = 2'd0;
    localparam logic [1:0] ROUTE_COEFF   = 2'd1;
    localparam logic [1:0] ROUTE_DATA    = 2'd2;
    localparam logic [1:0] ROUTE_RESULT  = 2'd3;

    localparam int MacEngineLatency = 5;
    localparam int ResultBufferSize = 24;

    localparam logic [31:0] FloatValue_1_0 = 32'h3f80_0000;

    // Control write bits and status read bits
    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_CLEAR_BIT    = 1;
    localparam int STAT_BUSY_BIT     = 0;
    localparam int STAT_OVERFLOW_BIT = 2;

endpackage

// File: rtl/accl_conv_sequencer_fifo.sv
// Result FIFO with wrap-around pointers for any depth (not only powers of two).
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module accl_result_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [DATA_W-1:0]            head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push_fire;
    logic              pop_fire;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head      = mem[rd_ptr_reg];
    assign pop_fire  = pop && !empty && !clear;
    assign push_fire = push && !clear && (!full || pop_fire);

    // Storage array, no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear behaves like a reset of the queue
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wrap_inc(wr_ptr_reg);
            end
            if (pop_fire) begin
                rd_ptr_reg <= wrap_inc(rd_ptr_reg);
            end
            if (push_fire && !pop_fire) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!push_fire && pop_fire) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/accl_conv_sequencer.sv
// Convolution sequencer: streams coefficient/data pairs into an external MAC,
// waits out the MAC latency, and queues each result for bus readback.
module accl_conv_sequencer
    import AcceleratorPackage::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int NUM_COEFFS   = 9,
    parameter int MAC_LATENCY  = MacEngineLatency,
    parameter int RESULT_DEPTH = ResultBufferSize
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic              avs_read,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_result,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - AddrRoutingBits;
    localparam int SEL_W = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
    localparam int LAT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam int CNT_W = $clog2(RESULT_DEPTH + 1);

    MacStateType       state_reg, state_next;
    logic [SEL_W-1:0]  idx_reg, idx_next;
    logic [LAT_W-1:0]  wait_reg, wait_next;
    logic              overflow_reg;
    logic              rdvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [DATA_W-1:0] coeff_mem [NUM_COEFFS];
    logic [DATA_W-1:0] data_mem  [NUM_COEFFS];

    logic [1:0]        route;
    logic [IDX_W-1:0]  index;
    logic              index_ok;
    logic              wr_en;
    logic              start_cmd;
    logic              clear_cmd;
    logic              rd_result;
    logic              last_tap;
    logic              push;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  result_count;

    assign route     = avs_address[ADDR_W-1 -: AddrRoutingBits];
    assign index     = avs_address[IDX_W-1:0];
    assign index_ok  = (32'(index) < 32'(NUM_COEFFS));
    // A read and a write in the same cycle: the read wins, the write is dropped
    assign wr_en     = avs_write && !avs_read;
    assign clear_cmd = wr_en && (route == ROUTE_CONTROL) && avs_writedata[CTRL_CLEAR_BIT];
    assign start_cmd = wr_en && (route == ROUTE_CONTROL) && avs_writedata[CTRL_START_BIT] && !busy;
    assign rd_result = avs_read && (route == ROUTE_RESULT);
    assign last_tap  = (idx_reg == SEL_W'(NUM_COEFFS - 1));
    assign push      = (state_reg == s_ReadResult);

    assign busy      = (state_reg != s_Idle);
    assign mac_valid = (state_reg == s_ReadInput);
    assign mac_first = mac_valid && (idx_reg == '0);
    assign mac_last  = mac_valid && last_tap;
    assign mac_a     = mac_valid ? coeff_mem[idx_reg] : '0;
    assign mac_b     = mac_valid ? data_mem[idx_reg]  : '0;

    assign avs_readdata      = rdata_reg;
    assign avs_readdatavalid = rdvalid_reg;

    // Operand tables are frozen while a sequence is in flight
    always_ff @(posedge clk) begin
        if (wr_en && !busy && index_ok) begin
            if (route == ROUTE_COEFF) begin
                coeff_mem[index[SEL_W-1:0]] <= avs_writedata;
            end
            if (route == ROUTE_DATA) begin
                data_mem[index[SEL_W-1:0]] <= avs_writedata;
            end
        end
    end

    // FSM state and tap/latency counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= s_Idle;
            idx_reg   <= '0;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            wait_reg  <= wait_next;
        end
    end

    // Next-state: feed every tap, wait the MAC latency, then capture one result
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        wait_next  = wait_reg;
        case (state_reg)
            s_Idle: begin
                if (start_cmd) begin
                    state_next = s_ReadInput;
                    idx_next   = '0;
                end
            end
            s_ReadInput: begin
                if (last_tap) begin
                    state_next = s_WaitForCalc;
                    wait_next  = '0;
                end else begin
                    idx_next = idx_reg + SEL_W'(1);
                end
            end
            s_WaitForCalc: begin
                if (wait_reg == LAT_W'(MAC_LATENCY - 1)) begin
                    state_next = s_ReadResult;
                end else begin
                    wait_next = wait_reg + LAT_W'(1);
                end
            end
            s_ReadResult: begin
                state_next = s_Idle;
            end
            default: begin
                state_next = s_Idle;
            end
        endcase
    end

    // Sticky overflow: a result arrived with no room and nothing being popped
    always_ff @(posedge clk) begin
        if (reset || clear_cmd) begin
            overflow_reg <= 1'b0;
        end else if (push && fifo_full && !rd_result) begin
            overflow_reg <= 1'b1;
        end
    end

    // Status word assembly for control-region reads
    always_comb begin
        status_word                    = '0;
        status_word[STAT_BUSY_BIT]     = busy;
        status_word[STAT_OVERFLOW_BIT] = overflow_reg;
        status_word[15:8]              = 8'(result_count);
    end

    // Registered read response, one cycle after the request
    always_ff @(posedge clk) begin
        if (reset) begin
            rdvalid_reg <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            rdvalid_reg <= avs_read;
            if (avs_read) begin
                case (route)
                    ROUTE_CONTROL: rdata_reg <= status_word;
                    ROUTE_RESULT:  rdata_reg <= fifo_empty ? '0 : fifo_head;
                    default:       rdata_reg <= '0;
                endcase
            end
        end
    end

    accl_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESULT_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mac_result),
        .pop       (rd_result),
        .clear     (clear_cmd),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (result_count)
    );

endmodule

// File: tb/tb_accl_conv_sequencer.sv
// Self-checking bench: directed scenarios plus a random bus phase, all compared
// against a cycle-timeline model (queue of results, busy window, sticky overflow).
`timescale 1ns/1ps
module tb_accl_conv_sequencer;
    import AcceleratorPackage::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int N       = 9;
    localparam int L       = 5;
    localparam int DEPTH   = 24;
    localparam int SEQ_END = N + L + 1;   // result capture cycle, relative to start

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] avs_address = '0;
    logic              avs_write = 1'b0;
    logic [DATA_W-1:0] avs_writedata = '0;
    logic              avs_read = 1'b0;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_readdatavalid;
    logic              mac_valid, mac_first, mac_last;
    logic [DATA_W-1:0] mac_a, mac_b;
    logic [DATA_W-1:0] mac_result = '0;
    logic              busy;

    always #5 clk = ~clk;

    accl_conv_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .mac_valid         (mac_valid),
        .mac_first         (mac_first),
        .mac_last          (mac_last),
        .mac_a             (mac_a),
        .mac_b             (mac_b),
        .mac_result        (mac_result),
        .busy              (busy)
    );

    // Mock MAC: integer dot product, presented only in the capture cycle
    int          neg_cyc   = 0;
    int          ready_cyc = -100;
    logic [31:0] acc       = '0;
    always @(negedge clk) begin
        neg_cyc++;
        if (mac_valid) begin
            if (mac_first) acc = mac_a * mac_b;
            else           acc = acc + mac_a * mac_b;
            if (mac_last)  ready_cyc = neg_cyc + L + 1;
        end
        mac_result = (neg_cyc == ready_cyc) ? acc : (32'hBAD0_0000 ^ 32'(neg_cyc));
    end

    // Reference model state
    logic [31:0] coeff_sh [N];
    logic [31:0] data_sh  [N];
    logic [31:0] q [$];
    bit          ovf_m      = 1'b0;
    bit          seq_active = 1'b0;
    int          start_c    = 0;
    logic [31:0] seq_val    = '0;
    int          cyc        = 0;
    logic [31:0] last_rd    = '0;
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          n_fail     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dot();
        logic [31:0] s = '0;
        for (int i = 0; i < N; i++) s = s + coeff_sh[i] * data_sh[i];
        return s;
    endfunction

    // One bus cycle: check outputs, advance the model, clock, check the response
    task automatic tick();
        bit          exp_busy, in_rd, exp_rv, wr, clr, st, push_ev;
        int          k;
        logic [31:0] exp_rd;
        logic [1:0]  rt;
        logic [7:0]  ix;
        rt = avs_address[9:8];
        ix = avs_address[7:0];
        exp_busy = seq_active && (cyc >= start_c + 1) && (cyc <= start_c + SEQ_END);
        k = cyc - start_c - 1;
        in_rd = seq_active && (k >= 0) && (k < N);
        check("busy", 32'(busy), 32'(exp_busy));
        check("mac_valid", 32'(mac_valid), 32'(in_rd));
        if (in_rd) begin
            check("mac_first", 32'(mac_first), 32'(k == 0));
            check("mac_last", 32'(mac_last), 32'(k == N - 1));
            check("mac_a", mac_a, coeff_sh[4'(k)]);
            check("mac_b", mac_b, data_sh[4'(k)]);
        end
        exp_rv = avs_read && !reset;
        exp_rd = '0;
        if (avs_read) begin
            if (rt == ROUTE_CONTROL)
                exp_rd = {16'h0, 8'(q.size()), 5'h0, ovf_m, 1'b0, exp_busy};
            else if (rt == ROUTE_RESULT && q.size() > 0)
                exp_rd = q[0];
        end
        if (reset) begin
            seq_active = 1'b0;
            q.delete();
            ovf_m = 1'b0;
        end else begin
            wr = avs_write && !avs_read;
            clr = wr && (rt == ROUTE_CONTROL) && avs_writedata[1];
            st = wr && (rt == ROUTE_CONTROL) && avs_writedata[0] && !exp_busy;
            push_ev = seq_active && (cyc == start_c + SEQ_END);
            if (avs_read && rt == ROUTE_RESULT && q.size() > 0) void'(q.pop_front());
            if (clr) begin
                q.delete();
                ovf_m = 1'b0;
            end else if (push_ev) begin
                if (q.size() < DEPTH) q.push_back(seq_val);
                else ovf_m = 1'b1;
            end
            if (push_ev) seq_active = 1'b0;
            if (st) begin
                seq_active = 1'b1;
                start_c = cyc;
                seq_val = dot();
            end
            if (wr && !exp_busy && ix < N) begin
                if (rt == ROUTE_COEFF) coeff_sh[ix[3:0]] = avs_writedata;
                if (rt == ROUTE_DATA)  data_sh[ix[3:0]]  = avs_writedata;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("readdatavalid", 32'(avs_readdatavalid), 32'(exp_rv));
        if (exp_rv) begin
            check("readdata", avs_readdata, exp_rd);
            last_rd = avs_readdata;
        end
    endtask

    task automatic do_write(input logic [1:0] rt, input int ix, input logic [31:0] d);
        avs_address = {rt, 8'(ix)};
        avs_writedata = d;
        avs_write = 1'b1;
        $display("[%0d] write route=%0d idx=%0d data=%h", cyc, rt, ix, d);
        tick();
        avs_write = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] rt);
        avs_address = {rt, 8'h00};
        avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        $display("[%0d] read  route=%0d data=%h", cyc, rt, last_rd);
    endtask

    task automatic do_idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        $display("[%0d] reset", cyc);
        tick();
        reset = 1'b0;
    endtask

    task automatic run_seq();
        do_write(ROUTE_CONTROL, 0, 32'h1);
        do_idle(SEQ_END);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mac_valid", 32'(mac_valid), 32'h0);
        check("rst_mac_first", 32'(mac_first), 32'h0);
        check("rst_mac_last", 32'(mac_last), 32'h0);
        check("rst_mac_a", mac_a, 32'h0);
        check("rst_mac_b", mac_b, 32'h0);
        check("rst_rdvalid", 32'(avs_readdatavalid), 32'h0);
        check("rst_rdata", avs_readdata, 32'h0);
        reset = 1'b0;
        do_read(ROUTE_CONTROL);
        check("rst_status", last_rd, 32'h0);

        // Unit coefficients over a ramp; busy window and MAC stream timing
        for (int i = 0; i < N; i++) begin
            do_write(ROUTE_COEFF, i, FloatValue_1_0);
            do_write(ROUTE_DATA, i, 32'(i));
        end
        run_seq();
        do_idle(1);
        do_read(ROUTE_CONTROL);
        check("ramp_status", last_rd, 32'h100);
        do_read(ROUTE_RESULT);

        // Known MAC value comes back through the FIFO
        do_write(ROUTE_COEFF, 0, 32'h1);
        do_write(ROUTE_DATA, 0, 32'h4110_0000);
        for (int i = 1; i < N; i++) do_write(ROUTE_DATA, i, 32'h0);
        run_seq();
        do_read(ROUTE_CONTROL);
        check("one_status", last_rd, 32'h100);
        do_read(ROUTE_RESULT);
        check("one_result", last_rd, 32'h4110_0000);
        do_read(ROUTE_CONTROL);
        check("one_drained", last_rd, 32'h0);

        // Overflow: 25 results into 24 slots, then drain in order
        for (int s = 0; s < DEPTH + 1; s++) begin
            do_write(ROUTE_DATA, 0, 32'(s + 1));
            run_seq();
        end
        do_read(ROUTE_CONTROL);
        check("full_status", last_rd, 32'h1804);
        for (int r = 0; r < DEPTH; r++) do_read(ROUTE_RESULT);
        do_read(ROUTE_RESULT);
        check("empty_read", last_rd, 32'h0);

        // Pop coincident with push on a full FIFO
        do_write(ROUTE_CONTROL, 0, 32'h2);
        for (int s = 0; s < DEPTH; s++) begin
            do_write(ROUTE_DATA, 0, 32'(100 + s));
            run_seq();
        end
        do_read(ROUTE_CONTROL);
        check("refill_status", last_rd, 32'h1800);
        do_write(ROUTE_DATA, 0, 32'd999);
        do_write(ROUTE_CONTROL, 0, 32'h1);
        do_idle(SEQ_END - 1);
        do_read(ROUTE_RESULT);
        check("popush_head", last_rd, 32'd100);
        do_read(ROUTE_CONTROL);
        check("popush_status", last_rd, 32'h1800);

        // Writes while busy are ignored
        do_write(ROUTE_CONTROL, 0, 32'h2);
        do_write(ROUTE_DATA, 0, 32'd7);
        do_write(ROUTE_CONTROL, 0, 32'h1);
        do_idle(2);
        do_write(ROUTE_COEFF, 0, 32'd5);
        do_idle(1);
        do_write(ROUTE_CONTROL, 0, 32'h1);
        do_idle(SEQ_END - 5);
        do_read(ROUTE_RESULT);
        check("busy_write_ignored", last_rd, 32'd7);

        // Reset mid-sequence aborts with no push
        do_write(ROUTE_CONTROL, 0, 32'h1);
        do_idle(4);
        do_write(ROUTE_CONTROL, 0, 32'h1);
        do_reset();
        check("busy_after_reset", 32'(busy), 32'h0);
        do_idle(20);
        do_read(ROUTE_CONTROL);
        check("reset_no_push", last_rd, 32'h0);
        for (int i = 0; i < N; i++) begin
            do_write(ROUTE_COEFF, i, 32'($urandom_range(1, 255)));
            do_write(ROUTE_DATA, i, 32'($urandom_range(1, 255)));
        end
        run_seq();
        do_read(ROUTE_CONTROL);
        check("post_reset_status", last_rd, 32'h100);
        do_read(ROUTE_RESULT);

        // Out-of-range index writes, then clear while busy
        do_write(ROUTE_COEFF, 9, 32'hFFFF_FFFF);
        do_write(ROUTE_DATA, 9, 32'hFFFF_FFFF);
        do_write(ROUTE_COEFF, 13, 32'hFFFF_FFFF);
        run_seq();
        do_read(ROUTE_RESULT);
        run_seq();
        do_write(ROUTE_CONTROL, 0, 32'h1);
        do_idle(3);
        do_write(ROUTE_CONTROL, 0, 32'h2);
        do_idle(SEQ_END - 4);
        do_read(ROUTE_CONTROL);
        check("clear_busy_status", last_rd, 32'h100);
        do_read(ROUTE_RESULT);

        // Random bus traffic against the model
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op < 5) begin
                do_write(ROUTE_CONTROL, 0, ($urandom_range(0, 15) == 0) ? 32'h2 : 32'h1);
            end else if (op < 9) begin
                do_write(($urandom_range(0, 1) == 0) ? ROUTE_COEFF : ROUTE_DATA,
                         $urandom_range(0, 15), $urandom);
            end else if (op < 15) begin
                do_read(ROUTE_RESULT);
            end else if (op < 17) begin
                do_read(ROUTE_CONTROL);
            end else if (op < 18) begin
                avs_address = {ROUTE_CONTROL, 8'h00};
                avs_writedata = 32'h3;
                avs_write = 1'b1;
                avs_read = 1'b1;
                tick();
                avs_write = 1'b0;
                avs_read = 1'b0;
                $display("[%0d] read+write control data=%h", cyc, last_rd);
            end else begin
                do_idle($urandom_range(1, 6));
            end
        end
        do_idle(SEQ_END + 1);
        do_read(ROUTE_CONTROL);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
